// File: rtl/mca_arb_pkg.sv
// Shared types and width helpers for the MCA/MCS event arbiter.
// MCA_ARB_OVF_MARK_EN adds a per-word overflow flag bit to the FIFO word.
package mca_arb_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} arb_state_e;

`ifdef MCA_ARB_OVF_MARK_EN
  localparam int OVF_W = 1;
`else
  localparam int OVF_W = 0;
`endif

  function automatic int chan_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  // FIFO word layout: {[ovf], chan, peak, time}
  function automatic int word_w(input int nch, input int pw, input int tw);
    return OVF_W + chan_w(nch) + pw + tw;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] cnt, input logic [31:0] inc,
                                          input int w);
    logic [32:0] lim;
    logic [32:0] sum;
    lim = (33'd1 << w) - 33'd1;
    sum = {1'b0, cnt} + {1'b0, inc};
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last grant, pointer resets to 0.
module rr_arbiter import mca_arb_pkg::*; #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 en,
  output logic [N-1:0]         gnt,
  output logic [chan_w(N)-1:0] gnt_idx,
  output logic                 gnt_vld
);
  localparam int IW = chan_w(N);

  logic [IW-1:0] ptr_q;

  always_comb begin
    int c;
    c       = 0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int k = 0; k < N; k++) begin
      c = (int'(ptr_q) + k) % N;
      if (en && !gnt_vld && req[c]) begin
        gnt_vld = 1'b1;
        gnt[c]  = 1'b1;
        gnt_idx = IW'(c);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr_q <= '0;
    else if (gnt_vld) ptr_q <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
  end

endmodule

// File: rtl/mca_event_arbiter.sv
// Per-channel one-deep event slots, round-robin drain to a shared FIFO, run/preset FSM.
// Optional MCA_ARB_OVF_MARK_EN: sticky per-channel drop flag as fifo_din MSB.
//
// state | meaning
// IDLE  | waiting for run rising edge
// RUN   | capturing flagged events
// DRAIN | capture stopped, emptying pending slots
// DONE  | all slots written; leave when run is low
module mca_event_arbiter import mca_arb_pkg::*; #(
  parameter int NCH = 4,
  parameter int PW  = 14,
  parameter int TW  = 18,
  parameter int DW  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          run,
  input  logic [31:0]                   preset,
  input  logic [NCH-1:0]                ch_wflg,
  input  logic [NCH*PW-1:0]             ch_peak,
  input  logic [NCH*TW-1:0]             ch_time,
  input  logic                          fifo_full,
  output logic                          fifo_wr,
  output logic [word_w(NCH,PW,TW)-1:0]  fifo_din,
  output logic [31:0]                   ev_cnt,
  output logic [DW-1:0]                 drop_cnt,
  output logic                          busy,
  output logic                          done
);
  localparam int CW = chan_w(NCH);
  localparam int FW = word_w(NCH, PW, TW);

  arb_state_e     state_q, state_d;
  logic           run_q;
  logic [31:0]    preset_q;
  logic [NCH-1:0] pend_q;
  logic [PW-1:0]  peak_q [NCH];
  logic [TW-1:0]  time_q [NCH];

  logic [NCH-1:0] gnt, cap, drp;
  logic [CW-1:0]  gnt_idx;
  logic           gnt_vld, start;
  logic [31:0]    n_cap, n_drop, ev_next;
  logic [FW-1:0]  word_d;

  rr_arbiter #(.N(NCH)) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (pend_q),
    .en      (!fifo_full),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // Lowest channels consume the remaining preset budget first; flags past it are ignored.
  always_comb begin
    cap   = '0;
    drp   = '0;
    n_cap = '0;
    if (state_q == RUN) begin
      for (int i = 0; i < NCH; i++) begin
        if (ch_wflg[i] && (preset_q == '0 || ev_cnt + n_cap < preset_q)) begin
          if (!pend_q[i] || gnt[i]) begin
            cap[i] = 1'b1;
            n_cap  = n_cap + 32'd1;
          end else begin
            drp[i] = 1'b1;
          end
        end
      end
    end
  end

  assign n_drop  = 32'($countones(drp));
  assign ev_next = ev_cnt + n_cap;
  assign start   = (state_q == IDLE) && (state_d == RUN);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (run && !run_q) state_d = RUN;
      RUN:     if (!run || (preset_q != '0 && ev_next == preset_q)) state_d = DRAIN;
      DRAIN:   if (pend_q == '0) state_d = DONE;
      DONE:    if (!run) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef MCA_ARB_OVF_MARK_EN
  logic [NCH-1:0] ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     ovf_q <= '0;
    else if (start) ovf_q <= '0;
    else            ovf_q <= (ovf_q & ~gnt) | drp;
  end

  assign word_d = {ovf_q[gnt_idx], gnt_idx, peak_q[gnt_idx], time_q[gnt_idx]};
`else
  assign word_d = {gnt_idx, peak_q[gnt_idx], time_q[gnt_idx]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      run_q    <= 1'b0;
      preset_q <= '0;
      pend_q   <= '0;
      ev_cnt   <= '0;
      drop_cnt <= '0;
      fifo_wr  <= 1'b0;
      fifo_din <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run;
      fifo_wr <= gnt_vld;
      if (gnt_vld) fifo_din <= word_d;
      if (start) begin
        preset_q <= preset;
        pend_q   <= '0;
        ev_cnt   <= '0;
        drop_cnt <= '0;
      end else begin
        pend_q   <= (pend_q & ~gnt) | cap;
        ev_cnt   <= ev_next;
        drop_cnt <= DW'(sat_add(32'(drop_cnt), n_drop, DW));
      end
    end
  end

  // Slot payload needs no reset: it is only read while its pending bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (cap[i]) begin
        peak_q[i] <= ch_peak[i*PW +: PW];
        time_q[i] <= ch_time[i*TW +: TW];
      end
    end
  end

  assign busy = (state_q == RUN) || (state_q == DRAIN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_mca_event_arbiter.sv
// Directed and randomized bench for mca_event_arbiter against a cycle-level reference model.
module tb_mca_event_arbiter;
  localparam int NCH = 4;
  localparam int PW  = 14;
  localparam int TW  = 18;
  localparam int DW  = 4;
`ifdef MCA_ARB_OVF_MARK_EN
  localparam int FW  = 1 + 2 + PW + TW;
`else
  localparam int FW  = 2 + PW + TW;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              run = 1'b0;
  logic              fifo_full = 1'b0;
  logic [31:0]       preset = '0;
  logic [NCH-1:0]    ch_wflg = '0;
  logic [NCH*PW-1:0] ch_peak = '0;
  logic [NCH*TW-1:0] ch_time = '0;
  logic              fifo_wr;
  logic [FW-1:0]     fifo_din;
  logic [31:0]       ev_cnt;
  logic [DW-1:0]     drop_cnt;
  logic              busy, done;

  always #4 clk = ~clk;

  mca_event_arbiter #(.NCH(NCH), .PW(PW), .TW(TW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .preset    (preset),
    .ch_wflg   (ch_wflg),
    .ch_peak   (ch_peak),
    .ch_time   (ch_time),
    .fifo_full (fifo_full),
    .fifo_wr   (fifo_wr),
    .fifo_din  (fifo_din),
    .ev_cnt    (ev_cnt),
    .drop_cnt  (drop_cnt),
    .busy      (busy),
    .done      (done)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int n_words  = 0;

  // Reference model; m_state: 0 idle, 1 acquiring, 2 draining, 3 finished
  int            m_state;
  bit            m_pend [NCH];
  bit            m_ovf  [NCH];
  logic [PW-1:0] m_peak [NCH];
  logic [TW-1:0] m_time [NCH];
  int            m_ptr;
  longint        m_ev;
  int            m_drop;
  logic [31:0]   m_preset;
  bit            m_run_q;
  bit            m_wr;
  logic [FW-1:0] m_din;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_state = 0; m_ptr = 0; m_ev = 0; m_drop = 0; m_preset = '0;
    m_run_q = 0; m_wr = 0; m_din = '0;
    for (int i = 0; i < NCH; i++) begin
      m_pend[i] = 0; m_ovf[i] = 0; m_peak[i] = '0; m_time[i] = '0;
    end
  endtask

  task automatic model_edge();
    int  g;
    int  ncap;
    int  ndrop;
    bit  all_empty;
    g = -1; ncap = 0; ndrop = 0; all_empty = 1;
    for (int i = 0; i < NCH; i++) if (m_pend[i]) all_empty = 0;
    if (!fifo_full)
      for (int k = 0; k < NCH; k++)
        if (g < 0 && m_pend[(m_ptr + k) % NCH]) g = (m_ptr + k) % NCH;
    m_wr = (g >= 0);
    if (g >= 0) begin
`ifdef MCA_ARB_OVF_MARK_EN
      m_din = {m_ovf[g], g[1:0], m_peak[g], m_time[g]};
`else
      m_din = {g[1:0], m_peak[g], m_time[g]};
`endif
      m_pend[g] = 0; m_ovf[g] = 0; m_ptr = (g + 1) % NCH;
    end
    if (m_state == 1)
      for (int i = 0; i < NCH; i++)
        if (ch_wflg[i] && (m_preset == 0 || m_ev + ncap < longint'(m_preset))) begin
          if (!m_pend[i]) begin
            m_pend[i] = 1; m_peak[i] = ch_peak[i*PW +: PW]; m_time[i] = ch_time[i*TW +: TW];
            ncap++;
          end else begin
            ndrop++; m_ovf[i] = 1;
          end
        end
    m_ev   = (m_ev + ncap) % (64'd1 << 32);
    m_drop = (m_drop + ndrop > (1 << DW) - 1) ? (1 << DW) - 1 : m_drop + ndrop;
    case (m_state)
      0: if (run && !m_run_q) begin
           m_state = 1; m_ev = 0; m_drop = 0; m_preset = preset;
           for (int i = 0; i < NCH; i++) begin m_pend[i] = 0; m_ovf[i] = 0; end
         end
      1: if (!run || (m_preset != 0 && m_ev == longint'(m_preset))) m_state = 2;
      2: if (all_empty) m_state = 3;
      default: if (!run) m_state = 0;
    endcase
    m_run_q = run;
  endtask

  task automatic check_all();
    chk("fifo_wr", fifo_wr, m_wr);
    if (m_wr) chk("fifo_din", fifo_din, m_din);
    chk("ev_cnt", ev_cnt, m_ev[31:0]);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("busy", busy, m_state == 1 || m_state == 2);
    chk("done", done, m_state == 3);
    if (fifo_wr) n_words++;
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic rand_data();
    for (int i = 0; i < NCH; i++) begin
      ch_peak[i*PW +: PW] = PW'($urandom);
      ch_time[i*TW +: TW] = TW'($urandom);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_wr"}, fifo_wr, 0);
    chk({tag, "_din"}, fifo_din, 0);
    chk({tag, "_ev"}, ev_cnt, 0);
    chk({tag, "_drop"}, drop_cnt, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] exp_w;
    logic [PW-1:0] first_peak;
    logic [TW-1:0] first_time;
    int            wait_n;
    m_reset();
    #13;
    reset_checks("reset");
    @(negedge clk); rst_n = 1'b1;
    cyc();

    // two 4-channel bursts, grant order ch0..ch3 each time
    run = 1'b1; cyc();
    for (int b = 0; b < 2; b++) begin
      rand_data(); ch_wflg = 4'hF; cyc(); ch_wflg = '0;
      for (int w = 0; w < 4; w++) begin
        cyc();
        chk("burst_wr", fifo_wr, 1);
        chk("burst_chan", fifo_din[PW+TW +: 2], w);
      end
      cyc();
    end

    // single event on ch2
    ch_peak[2*PW +: PW] = 14'h0123; ch_time[2*TW +: TW] = 18'h00456;
    ch_wflg = 4'b0100; cyc(); ch_wflg = '0;
    chk("single_early", fifo_wr, 0);
    cyc();
    exp_w = FW'({2'd2, 14'h0123, 18'h00456});
    chk("single_wr", fifo_wr, 1);
    chk("single_din", fifo_din, exp_w);
    chk("single_ev", ev_cnt, 9);
    cyc();

    // backpressure: second ch1 event is dropped, first is kept
    fifo_full = 1'b1; n_words = 0;
    rand_data(); first_peak = ch_peak[PW +: PW]; first_time = ch_time[TW +: TW];
    ch_wflg = 4'b0010; cyc(); ch_wflg = '0; cyc();
    rand_data(); ch_wflg = 4'b0010; cyc(); ch_wflg = '0;
    for (int i = 0; i < 3; i++) cyc();
    chk("bp_drop", drop_cnt, 1);
    chk("bp_nowr", n_words, 0);
    fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (fifo_wr) begin
`ifdef MCA_ARB_OVF_MARK_EN
        exp_w = {1'b1, 2'd1, first_peak, first_time};
`else
        exp_w = {2'd1, first_peak, first_time};
`endif
        chk("bp_word", fifo_din, exp_w);
      end
    end
    chk("bp_count", n_words, 1);

    run = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    chk("stop_idle", busy | done, 0);

    // preset limit of 3 on ch0
    preset = 32'd3; run = 1'b1; cyc(); n_words = 0;
    for (int e = 0; e < 5; e++) begin
      rand_data(); ch_wflg = 4'b0001; cyc(); ch_wflg = '0;
      for (int i = 0; i < 3; i++) cyc();
    end
    chk("preset_ev", ev_cnt, 3);
    chk("preset_words", n_words, 3);
    chk("preset_done", done, 1);
    run = 1'b0; cyc(); cyc();
    chk("preset_idle", done, 0);

    // drain on stop with backpressure
    preset = '0; run = 1'b1; cyc();
    fifo_full = 1'b1; rand_data(); ch_wflg = 4'b1001; cyc(); ch_wflg = '0;
    run = 1'b0; cyc();
    rand_data(); ch_wflg = 4'b0010; cyc(); ch_wflg = '0; cyc();
    chk("drain_busy", busy, 1);
    chk("drain_nocap", ev_cnt, 2);
    n_words = 0; fifo_full = 1'b0; wait_n = 0;
    while (!done && wait_n < 12) begin cyc(); wait_n++; end
    chk("drain_done", done, 1);
    chk("drain_words", n_words, 2);
    cyc(); cyc();

    // randomized acquisition, unlimited then with preset
    for (int pass = 0; pass < 2; pass++) begin
      preset = (pass == 0) ? 32'd0 : 32'($urandom_range(15, 40));
      run = 1'b1; cyc();
      for (int i = 0; i < 400; i++) begin
        rand_data();
        ch_wflg   = NCH'($urandom & $urandom);
        fifo_full = ($urandom_range(0, 3) == 0);
        cyc();
      end
      ch_wflg = '0; fifo_full = 1'b0; run = 1'b0;
      for (int i = 0; i < 12; i++) cyc();
    end

    // asynchronous reset while slots are pending
    run = 1'b1; cyc();
    fifo_full = 1'b1; rand_data(); ch_wflg = 4'hF; cyc(); ch_wflg = '0; cyc();
    #2 rst_n = 1'b0;
    #1;
    reset_checks("async");
    m_reset();
    @(negedge clk); run = 1'b0; fifo_full = 1'b0; rst_n = 1'b1;
    n_words = 0;
    for (int i = 0; i < 8; i++) cyc();
    chk("async_nowr", n_words, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
